// File: rtl/pwm_slew_driver_pkg.sv
// pwm_slew_driver_pkg: shared PWM constants and output polarity helper.
package pwm_slew_driver_pkg;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PERIOD = 256;

    function automatic logic inactive_level(input logic active_high);
        return !active_high;
    endfunction
endpackage

// File: rtl/pwm_slew_driver_period_counter.sv
// pwm_period_counter: free-running PWM period counter, cleared while disabled.
module pwm_period_counter
    import pwm_slew_driver_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic [$clog2(PERIOD)-1:0] cnt,
    output logic                      period_end
);
    localparam int CW = $clog2(PERIOD);

    assign period_end = enable && (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (!enable || period_end) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/pwm_slew_driver.sv
// pwm_slew_driver: LED PWM stage with valid/ready duty intake,
// period-boundary updates and per-period slew limiting.
module pwm_slew_driver
    import pwm_slew_driver_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PERIOD      = DEF_PERIOD,
    parameter int STEP        = 1,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_target,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_end,
    output logic [WIDTH-1:0] duty_cur,
    output logic             busy
);
    localparam int CW = $clog2(PERIOD);
    localparam int XW = CW > WIDTH ? CW : WIDTH;
    // a step wider than any possible distance always lands on the target
    localparam int unsigned STEP_C = STEP > (1 << WIDTH) ? (1 << WIDTH) : STEP;
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP_C);
    localparam logic AH = ACTIVE_HIGH != 0;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] target, pend, eff, slewed;
    logic [WIDTH:0]   diff;
    logic             pend_vld, xfer, up, pwm_raw;

    pwm_period_counter #(.PERIOD(PERIOD)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cnt       (cnt),
        .period_end(period_end)
    );

    assign duty_ready = !pend_vld;
    assign xfer       = duty_valid && duty_ready;
    assign eff        = pend_vld ? pend : target;
    assign busy       = duty_cur != eff;

    always_comb begin
        up      = eff > duty_cur;
        diff    = up ? {1'b0, eff} - {1'b0, duty_cur} : {1'b0, duty_cur} - {1'b0, eff};
        slewed  = diff <= STEP_W ? eff :
                  up ? duty_cur + STEP_W[WIDTH-1:0] : duty_cur - STEP_W[WIDTH-1:0];
        pwm_raw = enable && (XW'(cnt) < XW'(duty_cur));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_cur <= '0;
            target   <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            pwm_out  <= inactive_level(AH);
        end else begin
            if (xfer)
                pend <= duty_target;
            pend_vld <= xfer || (pend_vld && !period_end);
            if (period_end) begin
                target   <= eff;
                duty_cur <= slewed;
            end
            pwm_out <= AH ? pwm_raw : !pwm_raw;
        end
    end
endmodule

// File: tb/tb_pwm_slew_driver.sv
// tb_pwm_slew_driver: two polarity/period variants driven in lockstep against
// a per-period behavioural model.
module tb_pwm_slew_driver;
    logic       clk = 0, rst = 1, enable = 1, duty_valid = 0;
    logic [7:0] duty_target = 0;
    logic [1:0] pwm_o, rdy, pe, bsy;
    logic [7:0] cur0, cur1;
    int n_cmp = 0, n_bad = 0;
    int m_cnt[2], m_cur[2], m_tgt[2], m_pend[2], m_pv[2], m_pwm[2];

    always #5 clk = ~clk;

    pwm_slew_driver #(.WIDTH(8), .PERIOD(200), .STEP(16), .ACTIVE_HIGH(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .duty_target(duty_target),
        .duty_valid(duty_valid), .duty_ready(rdy[0]), .pwm_out(pwm_o[0]),
        .period_end(pe[0]), .duty_cur(cur0), .busy(bsy[0]));

    pwm_slew_driver #(.WIDTH(8), .PERIOD(64), .STEP(255), .ACTIVE_HIGH(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .duty_target(duty_target),
        .duty_valid(duty_valid), .duty_ready(rdy[1]), .pwm_out(pwm_o[1]),
        .period_end(pe[1]), .duty_cur(cur1), .busy(bsy[1]));

    function automatic int per(int i); return i == 0 ? 200 : 64; endfunction
    function automatic int stp(int i); return i == 0 ? 16 : 255; endfunction
    function automatic int ah(int i);  return i == 0 ? 1 : 0; endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_cur[i] = 0; m_tgt[i] = 0; m_pend[i] = 0; m_pv[i] = 0;
            m_pwm[i] = 1 - ah(i);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int eff = m_pv[i] ? m_pend[i] : m_tgt[i];
            chk($sformatf("pwm_out%0d", i), pwm_o[i], m_pwm[i]);
            chk($sformatf("duty_ready%0d", i), rdy[i], m_pv[i] ? 0 : 1);
            chk($sformatf("period_end%0d", i), pe[i], (enable && m_cnt[i] == per(i) - 1) ? 1 : 0);
            chk($sformatf("busy%0d", i), bsy[i], m_cur[i] != eff ? 1 : 0);
            chk($sformatf("duty_cur%0d", i), i == 0 ? cur0 : cur1, m_cur[i]);
        end
    endtask

    // effect of one clock edge on the model, given the inputs currently driven
    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            int  eff = m_pv[i] ? m_pend[i] : m_tgt[i];
            int  d   = eff - m_cur[i];
            bit  pend_end = enable && m_cnt[i] == per(i) - 1;
            bit  take = duty_valid && m_pv[i] == 0;
            m_pwm[i] = (enable && m_cnt[i] < m_cur[i]) ? ah(i) : 1 - ah(i);
            if (pend_end) begin
                m_tgt[i] = eff;
                m_cur[i] = d > stp(i) ? m_cur[i] + stp(i) : d < -stp(i) ? m_cur[i] - stp(i) : eff;
            end
            if (take) begin
                m_pend[i] = duty_target;
                m_pv[i]   = 1;
            end else if (pend_end) m_pv[i] = 0;
            m_cnt[i] = enable ? (m_cnt[i] + 1) % per(i) : 0;
        end
    endtask

    task automatic cyc(input logic e, input logic v, input logic [7:0] d);
        @(negedge clk);
        enable = e; duty_valid = v; duty_target = d;
        #1;
        check_all();
        advance();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        #1 check_all();
        rst = 0;
        advance();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 0);
    endtask

    task automatic count_hi(input int n, output int h0, output int h1);
        h0 = 0; h1 = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1, 0, 0);
            h0 += int'(pwm_o[0]);
            h1 += int'(pwm_o[1]);
        end
    endtask

    initial begin
        int h0, h1, saved;
        bit saw100;
        do_reset();
        chk("rst_pwm0", pwm_o[0], 0);
        chk("rst_ready0", rdy[0], 1);
        count_hi(600, h0, h1);
        chk("idle_hi0", h0, 0);
        chk("idle_hi1", h1, 600);

        cyc(1, 1, 200);
        run(15 * 200);
        chk("slew_done0", cur0, 200);
        chk("slew_busy0", bsy[0], 0);
        chk("step_done1", cur1, 200);
        count_hi(200, h0, h1);
        chk("full_hi0", h0, 200);
        chk("full_hi1", h1, 0);

        cyc(1, 1, 0);
        run(15 * 200);
        count_hi(200, h0, h1);
        chk("zero_hi0", h0, 0);
        chk("zero_hi1", h1, 200);

        cyc(1, 1, 64);
        run(6 * 200);
        for (int k = 0; k < 220 && m_cnt[0] != 120; k++) cyc(1, 0, 0);
        chk("reach_cnt120", m_cnt[0], 120);
        saved = cur0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("en_off_pwm0", pwm_o[0], 0);
        chk("en_off_cur0", cur0, saved);
        count_hi(200, h0, h1);
        chk("reen_hi0", h0, 64);
        chk("reen_hi1", h1, 1);

        saw100 = 0;
        cyc(1, 1, 100);
        for (int k = 0; k < 450; k++) begin
            cyc(1, 1, 50);
            if (cur1 == 100) saw100 = 1;
        end
        run(400);
        chk("bp_saw100", saw100, 1);
        chk("bp_final1", cur1, 50);

        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) do_reset();
            cyc($urandom_range(0, 31) != 0, $urandom_range(0, 39) == 0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_slew_driver.md
# pwm_slew_driver

LED PWM output stage that consumes a duty value from an upstream brightness generator (sine/ramp producer) and drives the LED pin. Duty changes are accepted through a valid/ready handshake and applied only on PWM period boundaries, so the output never glitches. The applied duty is slew-limited by at most STEP per PWM period.

## Interface
- WIDTH, 8: duty width in bits.
- PERIOD, 256: PWM period in clk cycles. Legal range is 2..2^16.
- STEP, 1: maximum change of the applied duty per PWM period. Legal range is ≥1.
- ACTIVE_HIGH, 1: 1 means the LED is on when pwm_out=1; 0 inverts the output.
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run PWM. When low, the counter is cleared and the output is inactive.
- duty_target  in  WIDTH  requested duty, in clk cycles-on per period.
- duty_valid  in  1  duty_target is valid this cycle.
- duty_ready  out  1  block can accept a duty value; combinational, equals !pend_vld.
- pwm_out  out  1  registered PWM output.
- period_end  out  1  combinational; equals enable && cnt==PERIOD-1.
- duty_cur  out  WIDTH  duty currently applied.
- busy  out  1  high while duty_cur differs from the effective target.

## Operation
- Registers: cnt [clog2(PERIOD)-1:0], duty_cur, target, pend (WIDTH), pend_vld, pwm_out.
- Reset values: cnt=0, duty_cur=0, target=0, pend_vld=0, pwm_out=inactive level (0 if ACTIVE_HIGH, else 1). As a result, duty_ready=1, period_end=0, busy=0.
- Handshake:
  - A transfer occurs when duty_valid && duty_ready; pend<=duty_target and pend_vld<=1.
  - While pend_vld=1, duty_valid is ignored and no transfer occurs. Upstream must hold its value.
- Effective target: eff = pend_vld ? pend : target.
- Counter: when enable=1, cnt increments and wraps from PERIOD-1 to 0. When enable=0, cnt<=0.
- On a period_end cycle:
  - target<=eff and pend_vld<=0.
  - duty_cur<=eff if |eff-duty_cur| ≤ STEP; otherwise duty_cur±STEP toward eff.
  - Slew arithmetic uses WIDTH+1 bits, with no wrap.
  - A transfer accepted in the same cycle lands in pend and is applied at the next period_end.
- Output: pwm_raw = enable && (cnt < duty_cur), compared zero-extended; pwm_out <= pwm_raw XNOR ACTIVE_HIGH.
  - duty_cur=0 gives 0 % on-time.
  - duty_cur ≥ PERIOD gives 100 % on-time.
- enable=0: slew is frozen and duty_cur/target are held. The handshake still accepts one value into pend.
- busy = (duty_cur != eff).

## Timing
- pwm_out lags cnt by exactly 1 cycle. After enable rises (cnt=0), the first active output cycle is the next cycle, and it lasts duty_cur cycles.
- A duty value accepted in cycle A affects duty_cur first at the earliest period_end strictly after A. It is then visible on pwm_out starting 2 cycles after that period_end (cnt=0 compare, then register).
- Reaching target from duty_cur takes ceil(|Δ|/STEP) periods.
- duty_ready falls the cycle after acceptance. It rises the cycle after the period_end that consumes pend.
- enable dropping mid-period: the next cycle has cnt=0 and the output inactive; no partial-period slew step occurs.
- Reset asserted mid-period forces all reset values immediately (asynchronous reset). Release takes effect on the next clk edge.

## Structure
- Shared package/header: PWM constants (default PERIOD, WIDTH) and the inactive-level function of ACTIVE_HIGH. The existing breathing-light stage uses the same constants.
- One sub-module, pwm_period_counter: holds cnt with enable/clear and produces period_end. The top holds the handshake, slew, and compare.
- Estimated size: about 150–200 lines of RTL.

## Test plan
- Reset/idle: assert rst with enable=1 → pwm_out=0, duty_cur=0, duty_ready=1. After release with no request, pwm_out stays 0 for 3 full periods.
- Step with large STEP: PERIOD=256, STEP=255; send 64 at cnt=10 → duty_cur becomes 64 at the cnt=255 edge. In the next period, pwm_out is high for exactly 64 cycles, starting the cycle after cnt=0.
- Slew: STEP=16, cur=0, send 200 → duty_cur goes 16, 32, …, 192, then 200 on successive period_ends. busy drops after the 200 step.
- Backpressure: send 100; hold duty_valid with 50 while duty_ready=0 → 50 is accepted only after the next period_end. Target then becomes 50 one period later; 100 is never skipped.
- Boundaries: duty 0 gives a flat 0; duty 255 with PERIOD=200 gives a constant 1; ACTIVE_HIGH=0 inverts both cases.
- Enable toggle mid-period (cnt=120) → pwm_out inactive next cycle and duty_cur unchanged. After re-enable, a full period starts at cnt=0.
